word_serializer: RTL and testbench
==================================

# word_serializer

Parametrised transmit-side word serializer feeding the UART transmitter. It accepts one WORD_W-bit word through a valid/ready handshake and optionally bit-reverses it. It then splits the word into WORD_W/SYM_W symbols and presents each symbol on Tx_DATA with a one-cycle Tx_WR strobe, pacing itself on the transmitter's Tx_BUSY. After the last symbol it returns to idle and accepts the next word, so any number of words can be sent back-to-back.

## Interface
- WORD_W, 16, input word width; must be a non-zero multiple of SYM_W.
- SYM_W, 8, symbol width on Tx_DATA.
- REVERSE, 1, 1: full WORD_W bit reversal before splitting (bit i takes in_data[WORD_W-1-i]); 0: no reversal.
- MSB_FIRST, 1, 1: most-significant symbol of the prepared word is sent first; 0: least-significant symbol first.
- clock  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds a word to send.
- in_ready  output  1  serializer can accept a word (high only in IDLE).
- in_data  input  WORD_W  word to send; sampled only on an accepting edge.
- Tx_BUSY  input  1  transmitter busy; a symbol is issued only when this is sampled low.
- Tx_WR  output  1  one-cycle write strobe to the transmitter.
- Tx_DATA  output  SYM_W  current symbol; valid while Tx_WR is high and held until the next strobe.
- done  output  1  one-cycle pulse after the last symbol of a word has been strobed.

## Operation
- N = WORD_W/SYM_W symbols per word. The symbol index counter is max(1, clog2(N)) bits wide. N=1 is legal.
- States: IDLE, SEND, GAP.
- IDLE:
  - in_ready=1.
  - If in_valid=1 at the edge: register the prepared word (reversed per REVERSE), set idx=0, go to SEND.
- SEND:
  - in_ready=0.
  - If Tx_BUSY is sampled low: Tx_WR<=1, Tx_DATA<=symbol idx, go to GAP.
  - Otherwise stay in SEND indefinitely; Tx_DATA keeps its last value.
- Symbol selection:
  - Symbol k for MSB_FIRST=1 is prepared[WORD_W-1-k*SYM_W -: SYM_W].
  - Symbol k for MSB_FIRST=0 is prepared[k*SYM_W +: SYM_W].
- GAP:
  - Tx_WR<=0 for exactly one cycle. Tx_BUSY is ignored here, because the transmitter raises it the cycle after the strobe.
  - If idx==N-1: done<=1, go to IDLE.
  - Otherwise: idx<=idx+1, go to SEND.
- in_valid is ignored outside IDLE. in_data changes after acceptance have no effect on the word being sent.
- Reset (asynchronous, any time, including mid-word):
  - Go to IDLE and discard the partial word.
  - Tx_WR=0, Tx_DATA=0, done=0, idx=0.
  - in_ready=0 while reset is high, then 1 from the first cycle after reset deasserts.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing
- Edge E0: word accepted (in_valid & in_ready).
- Edge E1: first Tx_WR rises if Tx_BUSY is low. Minimum latency from acceptance to the first strobe is 1 cycle.
- Tx_WR is high for exactly 1 cycle per symbol.
- Minimum strobe-to-strobe spacing is 2 cycles; each Tx_BUSY-high cycle sampled in SEND adds 1 cycle.
- done is high in the cycle after the last Tx_WR cycle; in_ready is high in that same cycle.
  - A new word can be accepted at that edge.
  - Best case, a word takes 2N cycles and consecutive words take 2N+1 cycles.
- Tx_DATA changes only on edges where Tx_WR rises, or on reset.

## Test plan
- Reset, default parameters, Tx_BUSY=0:
  - Stimulus: in_data=16'h1234.
  - Required: two strobes with Tx_DATA=8'h2C then 8'h48, 2 cycles apart; done 1 cycle after the second strobe; first strobe 1 cycle after acceptance.
- Default parameters, in_data=16'h0001, then 16'h8000 offered back-to-back:
  - Required: Tx_DATA sequence 8'h80, 8'h00, 8'h00, 8'h01.
  - Required: the second word is accepted in the cycle in_ready/done is high.
  - Required: exactly 4 strobes in total.
- WORD_W=32, SYM_W=8, REVERSE=0, MSB_FIRST=0:
  - Stimulus: in_data=32'hA1B2C3D4.
  - Required: Tx_DATA sequence D4, C3, B2, A1; in_data changed after acceptance does not alter the symbols.
- Default parameters, hold Tx_BUSY=1 for 5 cycles after the first strobe's GAP:
  - Required: no Tx_WR during the hold; Tx_DATA stays 8'h2C.
  - Required: the second strobe occurs on the first edge Tx_BUSY is sampled low.
- Reset asserted asynchronously between the first and second symbol:
  - Required: Tx_WR and done are low at once; Tx_DATA=0; no further strobes.
  - Required: after release, a new word 16'hFFFF produces 8'hFF, 8'hFF.
- WORD_W=8, SYM_W=8 (N=1), REVERSE=1:
  - Stimulus: in_data=8'h01.
  - Required: a single strobe with Tx_DATA=8'h80, then done, then return to IDLE.

Source files
------------

// File: rtl/word_serializer.sv
// word_serializer: accepts a word, optionally bit-reverses it and strobes it out symbol by symbol
module word_serializer #(
  parameter int WORD_W = 16,
  parameter int SYM_W = 8,
  parameter bit REVERSE = 1'b1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              Tx_BUSY,
  output logic              Tx_WR,
  output logic [SYM_W-1:0]  Tx_DATA,
  output logic              done
);
  localparam int N = WORD_W / SYM_W;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic [WORD_W-1:0] word, prepared;
  logic [SYM_W-1:0] sym;
  for (genvar b = 0; b < WORD_W; b++) begin : g_rev
    assign prepared[b] = REVERSE ? in_data[WORD_W-1-b] : in_data[b];
  end
  assign sym = SYM_W'(word >> (SYM_W * (MSB_FIRST ? N - 1 - int'(idx) : int'(idx))));
  // handshake, Tx_BUSY pacing, one-cycle strobes and the end-of-word pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      word <= '0;
      in_ready <= 1'b0;
      Tx_WR <= 1'b0;
      Tx_DATA <= '0;
      done <= 1'b0;
    end else begin
      Tx_WR <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE:
          if (in_ready && in_valid) begin
            word <= prepared;
            idx <= '0;
            in_ready <= 1'b0;
            state <= SEND;
          end else in_ready <= 1'b1;
        SEND:
          if (!Tx_BUSY) begin
            Tx_WR <= 1'b1;
            Tx_DATA <= sym;
            state <= GAP;
          end
        GAP:
          if (idx == IW'(N - 1)) begin
            done <= 1'b1;
            in_ready <= 1'b1;
            state <= IDLE;
          end else begin
            idx <= idx + 1'b1;
            state <= SEND;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: four parameterisations driven by directed and random traffic against a behavioural model
module tb_word_serializer;
  localparam int WWS [4] = '{16, 32, 8, 24};
  localparam bit RVS [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  localparam bit MSS [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v [4], busy [4], rdy [4], wr [4], dn [4];
  logic [31:0] d [4];
  logic [7:0] txd [4];
  int checks = 0, failures = 0, cyc_n = 0;
  logic [7:0] lg_d [4][4096];
  int lg_c [4][4096];
  int lg_n [4] = '{0, 0, 0, 0};
  int dn_c [4] = '{0, 0, 0, 0};
  logic [7:0] ms [4][4];
  int mk [4], mn [4];
  bit mg [4], mr [4], mw [4], md [4];
  logic [7:0] mdat [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  for (genvar i = 0; i < 4; i++) begin : g_dut
    word_serializer #(.WORD_W(WWS[i]), .SYM_W(8), .REVERSE(RVS[i]), .MSB_FIRST(MSS[i])) dut (
      .clk(clk), .rst(rst), .in_valid(v[i]), .in_ready(rdy[i]), .in_data(d[i][WWS[i]-1:0]),
      .Tx_BUSY(busy[i]), .Tx_WR(wr[i]), .Tx_DATA(txd[i]), .done(dn[i]));
  end

  // word -> list of symbols, straight from the reversal and ordering rules
  function automatic void load(int i);
    int ww = WWS[i];
    logic [31:0] w, r;
    w = d[i] & ((32'h1 << ww) - 32'h1);
    r = '0;
    for (int b = 0; b < ww; b++) r[b] = w[ww-1-b];
    if (RVS[i]) w = r;
    mn[i] = ww / 8;
    mk[i] = 0;
    for (int k = 0; k < mn[i]; k++) ms[i][k] = 8'(w >> (MSS[i] ? ww - 8 - 8 * k : 8 * k));
  endfunction

  // expected outputs after each edge: pending symbol list, one-cycle gap after each strobe
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 4; i++) begin
      mw[i] = 1'b0;
      md[i] = 1'b0;
      if (rst) begin
        mk[i] = 0; mn[i] = 0; mg[i] = 1'b0; mr[i] = 1'b0; mdat[i] = '0;
      end else if (mg[i]) begin
        mg[i] = 1'b0;
        if (mk[i] == mn[i]) begin md[i] = 1'b1; mr[i] = 1'b1; end
      end else if (mk[i] < mn[i]) begin
        if (!busy[i]) begin mdat[i] = ms[i][mk[i]]; mk[i]++; mw[i] = 1'b1; mg[i] = 1'b1; end
      end else if (!mr[i]) mr[i] = 1'b1;
      else if (v[i]) begin load(i); mr[i] = 1'b0; end
    end
  end

  function automatic void chk(string nm, int i, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%0h want=%0h at cycle %0d", nm, i, got, exp, cyc_n);
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("in_ready", i, 32'(rdy[i]), 32'(mr[i]));
      chk("Tx_WR", i, 32'(wr[i]), 32'(mw[i]));
      chk("done", i, 32'(dn[i]), 32'(md[i]));
      chk("Tx_DATA", i, 32'(txd[i]), 32'(mdat[i]));
      if (wr[i] && lg_n[i] < 4096) begin
        lg_d[i][lg_n[i]] = txd[i];
        lg_c[i][lg_n[i]] = cyc_n;
        lg_n[i]++;
      end
      if (dn[i]) dn_c[i] = cyc_n;
    end
  endtask

  task automatic offer(int i, logic [31:0] w, output int acc);
    int t = 0;
    v[i] = 1'b1;
    d[i] = w;
    while (!rdy[i] && t < 100) begin tick(); t++; end
    if (t >= 100) chk("offer_timeout", i, 32'd1, 32'd0);
    tick();
    acc = cyc_n;
    v[i] = 1'b0;
  endtask

  initial begin
    int a, a2, b;
    for (int i = 0; i < 4; i++) begin v[i] = 1'b0; d[i] = '0; busy[i] = 1'b0; end
    repeat (3) tick();
    chk("reset_ready", 0, 32'(rdy[0]), 32'd0);
    chk("reset_data", 0, 32'(txd[0]), 32'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_reset", 0, 32'(rdy[0]), 32'd1);
    // basic word, reversed and MSB first
    b = lg_n[0];
    offer(0, 32'h1234, a);
    repeat (6) tick();
    chk("t1_count", 0, lg_n[0] - b, 32'd2);
    chk("t1_sym0", 0, 32'(lg_d[0][b]), 32'h2C);
    chk("t1_sym1", 0, 32'(lg_d[0][b+1]), 32'h48);
    chk("t1_first_lat", 0, lg_c[0][b], a + 1);
    chk("t1_spacing", 0, lg_c[0][b+1], a + 3);
    chk("t1_done", 0, dn_c[0], a + 4);
    // back-to-back words, in_data changed while the first word is in flight
    b = lg_n[0];
    offer(0, 32'h0001, a);
    offer(0, 32'h8000, a2);
    repeat (6) tick();
    chk("t2_count", 0, lg_n[0] - b, 32'd4);
    chk("t2_sym0", 0, 32'(lg_d[0][b]), 32'h80);
    chk("t2_sym1", 0, 32'(lg_d[0][b+1]), 32'h00);
    chk("t2_sym2", 0, 32'(lg_d[0][b+2]), 32'h00);
    chk("t2_sym3", 0, 32'(lg_d[0][b+3]), 32'h01);
    chk("t2_accept_on_done", 0, a2, a + 5);
    chk("t2_done2", 0, dn_c[0], a2 + 4);
    // 32-bit, no reversal, LSB first
    b = lg_n[1];
    offer(1, 32'hA1B2C3D4, a);
    d[1] = 32'h5A5A5A5A;
    repeat (10) tick();
    chk("t3_count", 1, lg_n[1] - b, 32'd4);
    chk("t3_sym0", 1, 32'(lg_d[1][b]), 32'hD4);
    chk("t3_sym1", 1, 32'(lg_d[1][b+1]), 32'hC3);
    chk("t3_sym2", 1, 32'(lg_d[1][b+2]), 32'hB2);
    chk("t3_sym3", 1, 32'(lg_d[1][b+3]), 32'hA1);
    chk("t3_last", 1, lg_c[1][b+3], a + 7);
    // Tx_BUSY held after the first strobe
    offer(0, 32'h1234, a);
    tick();
    chk("t4_strobe1", 0, 32'(wr[0]), 32'd1);
    chk("t4_model_pin", 0, 32'(mdat[0]), 32'h2C);
    busy[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t4_hold_wr", 0, 32'(wr[0]), 32'd0);
      chk("t4_hold_data", 0, 32'(txd[0]), 32'h2C);
    end
    busy[0] = 1'b0;
    tick();
    chk("t4_strobe2", 0, 32'(wr[0]), 32'd1);
    chk("t4_sym2", 0, 32'(txd[0]), 32'h48);
    chk("t4_when", 0, cyc_n, a + 8);
    repeat (3) tick();
    // asynchronous reset between the first and second symbol
    b = lg_n[0];
    offer(0, 32'h1234, a);
    tick();
    chk("t5_strobe1", 0, 32'(txd[0]), 32'h2C);
    #1 rst = 1'b1;
    #1;
    chk("t5_wr_async", 0, 32'(wr[0]), 32'd0);
    chk("t5_done_async", 0, 32'(dn[0]), 32'd0);
    chk("t5_data_async", 0, 32'(txd[0]), 32'd0);
    chk("t5_ready_async", 0, 32'(rdy[0]), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("t5_ready_release", 0, 32'(rdy[0]), 32'd1);
    chk("t5_no_more", 0, lg_n[0] - b, 32'd1);
    offer(0, 32'hFFFF, a);
    repeat (5) tick();
    chk("t5_count", 0, lg_n[0] - b, 32'd3);
    chk("t5_sym0", 0, 32'(lg_d[0][b+1]), 32'hFF);
    chk("t5_sym1", 0, 32'(lg_d[0][b+2]), 32'hFF);
    // single-symbol word
    b = lg_n[2];
    offer(2, 32'h01, a);
    repeat (3) tick();
    chk("t6_count", 2, lg_n[2] - b, 32'd1);
    chk("t6_sym", 2, 32'(lg_d[2][b]), 32'h80);
    chk("t6_strobe_at", 2, lg_c[2][b], a + 1);
    chk("t6_done_at", 2, dn_c[2], a + 2);
    chk("t6_ready", 2, 32'(rdy[2]), 32'd1);
    // random traffic on all four configurations with occasional async resets
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        v[i] = 1'($urandom_range(0, 1));
        d[i] = $urandom;
        busy[i] = ($urandom_range(0, 3) == 0);
      end
      if (n % 997 == 500) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
